// File: rtl/router_pkg.sv
// Shared definitions for the router ingress packet transmitter:
// header field widths, the illegal address, FSM states and header packing.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PAYLOAD,
        PARITY,
        WAIT_ERR,
        DONE
    } tx_state_t;

    function automatic logic [7:0] pack_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for the transmitter: single-clock RAM,
// one write port, one combinational read port.
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the 1x3 router ingress.
// Define ROUTER_TX_ERR_INJECT_EN to add inject_err (inverted parity byte).
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    input  logic              pl_valid,
    input  logic [7:0]        pl_data,
    output logic              pl_ready,
    input  logic              busy,
    input  logic              err_in,
    output logic              pkt_valid,
    output logic [7:0]        data_out,
    output logic              tx_done,
    output logic              tx_err
);

    localparam int AW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(ERR_WAIT + 1);

    tx_state_t         state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [7:0]        parity_q;
    logic [AW-1:0]     wr_ptr, rd_ptr, last;
    logic [CW-1:0]     err_cnt;
    logic              err_q, inj_q, rdy_q;
    logic              legal, take, pl_fire;
    logic [7:0]        rd_data;

    assign legal   = (cmd_addr != ADDR_ILLEGAL) && (cmd_len != '0);
    assign take    = ~busy;
    assign pl_fire = pl_valid & pl_ready;
    assign last    = AW'(len_q - LEN_W'(1));

    router_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (pl_fire),
        .waddr (wr_ptr),
        .wdata (pl_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        pl_ready  = 1'b0;
        pkt_valid = 1'b0;
        data_out  = '0;
        tx_done   = 1'b0;
        tx_err    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = rdy_q;
                if (cmd_valid && rdy_q) begin
                    state_n = legal ? LOAD : DONE;
                end
            end
            LOAD: begin
                pl_ready = 1'b1;
                if (pl_valid && wr_ptr == last) begin
                    state_n = HDR;
                end
            end
            HDR: begin
                pkt_valid = 1'b1;
                data_out  = pack_header(len_q, addr_q);
                if (take) begin
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = rd_data;
                if (take && rd_ptr == last) begin
                    state_n = PARITY;
                end
            end
            PARITY: begin
                data_out = inj_q ? ~parity_q : parity_q;
                if (take) begin
                    state_n = WAIT_ERR;
                end
            end
            WAIT_ERR: begin
                if (take && err_cnt == CW'(ERR_WAIT - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                tx_done = 1'b1;
                tx_err  = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            parity_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_cnt  <= '0;
            err_q    <= 1'b0;
            inj_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= 1'b1;
            if (cmd_valid && cmd_ready) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                parity_q <= pack_header(cmd_len, cmd_addr);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                err_q    <= ~legal;
`ifdef ROUTER_TX_ERR_INJECT_EN
                inj_q    <= inject_err;
`else
                inj_q    <= 1'b0;
`endif
            end
            if (pl_fire) begin
                wr_ptr   <= wr_ptr + AW'(1);
                parity_q <= parity_q ^ pl_data;
            end
            if (state == PAYLOAD && take) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (state == PARITY) begin
                err_cnt <= '0;
            end
            // err_in is watched every cycle of the window, busy or not
            if (state == WAIT_ERR) begin
                err_q <= err_q | err_in;
                if (take) begin
                    err_cnt <= err_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: phase-level reference model,
// a router stand-in that captures bytes and flags parity errors.
module tb_router_pkt_tx;

    localparam int ERR_WAIT = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
`ifdef ROUTER_TX_ERR_INJECT_EN
    logic       inject_err;
`endif
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       err_in;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       tx_err;

    int checks = 0;
    int failures = 0;

    int busy_mode = 0;
    bit spurious = 1'b0;

    logic [7:0] pb [0:63];

    router_pkt_tx dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
`ifdef ROUTER_TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .err_in    (err_in),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase level) ----------------
    int         m_phase = 0;  // 0 idle, 1 load, 2 bus, 3 err window, 4 done
    int         m_len, m_cnt, m_idx, m_wcnt;
    bit         m_err, m_rdy, m_inj;
    logic [7:0] m_bytes [0:65];

    always @(negedge clock) begin
        if (!resetn) begin
            check("rst_pkt_valid", 32'(pkt_valid), 0);
            check("rst_data_out", 32'(data_out), 0);
            check("rst_cmd_ready", 32'(cmd_ready), 0);
            check("rst_tx_done", 32'(tx_done), 0);
            m_phase = 0;
            m_rdy = 1'b0;
        end else begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0 && m_rdy));
            check("pl_ready", 32'(pl_ready), 32'(m_phase == 1));
            check("tx_done", 32'(tx_done), 32'(m_phase == 4));
            if (m_phase == 4) check("tx_err", 32'(tx_err), 32'(m_err));
            if (m_phase == 2) begin
                check("bus_pkt_valid", 32'(pkt_valid), 32'(m_idx <= m_len));
                check("bus_data", 32'(data_out), 32'(m_bytes[m_idx]));
            end else begin
                check("quiet_pkt_valid", 32'(pkt_valid), 0);
                check("quiet_data", 32'(data_out), 0);
            end
            case (m_phase)
                0: if (cmd_valid && m_rdy) begin
                    m_len = int'(cmd_len);
                    m_bytes[0] = {cmd_len, cmd_addr};
`ifdef ROUTER_TX_ERR_INJECT_EN
                    m_inj = inject_err;
`else
                    m_inj = 1'b0;
`endif
                    if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                        m_phase = 4;
                        m_err = 1'b1;
                    end else begin
                        m_phase = 1;
                        m_cnt = 0;
                    end
                end
                1: if (pl_valid) begin
                    m_cnt++;
                    m_bytes[m_cnt] = pl_data;
                    if (m_cnt == m_len) begin
                        logic [7:0] p;
                        p = 8'h00;
                        for (int i = 0; i <= m_len; i++) p ^= m_bytes[i];
                        m_bytes[m_len + 1] = m_inj ? ~p : p;
                        m_phase = 2;
                        m_idx = 0;
                    end
                end
                2: if (!busy) begin
                    m_idx++;
                    if (m_idx == m_len + 2) begin
                        m_phase = 3;
                        m_wcnt = 0;
                        m_err = 1'b0;
                    end
                end
                3: begin
                    m_err = m_err | err_in;
                    if (!busy) m_wcnt++;
                    if (m_wcnt == ERR_WAIT) m_phase = 4;
                end
                default: m_phase = 0;
            endcase
            m_rdy = 1'b1;
        end
    end

    // ---------------- router stand-in ----------------
    logic [7:0] rx [0:64];
    int         rx_n = 0;
    bit         rx_act = 1'b0;
    logic [7:0] rx_par = 8'h00;
    int         pv_cnt = 0;
    int         c3c = 0;
    int         err_req = 0;

    always @(negedge clock) begin
        if (!resetn) begin
            rx_act = 1'b0;
        end else begin
            if (pkt_valid) begin
                pv_cnt++;
                if (data_out == 8'h3C) c3c++;
            end
            if (!busy) begin
                if (pkt_valid) begin
                    if (!rx_act) rx_n = 0;
                    if (rx_n < 65) begin
                        rx[rx_n] = data_out;
                        rx_n++;
                    end
                    rx_act = 1'b1;
                end else if (rx_act) begin
                    logic [7:0] x;
                    x = 8'h00;
                    for (int i = 0; i < rx_n; i++) x ^= rx[i];
                    rx_par = data_out;
                    if (x != data_out) err_req++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    int err_ack = 0;
    int hold = 0;

    always @(posedge clock) begin
        #1;
        case (busy_mode)
            1: busy = ($urandom_range(99) < 30);
            2: if (pkt_valid && data_out == 8'h3C && hold < 2) begin
                busy = 1'b1;
                hold++;
            end else begin
                busy = 1'b0;
            end
            default: busy = 1'b0;
        endcase
        if (busy_mode != 2) hold = 0;
        err_in = (err_req != err_ack) || (spurious && $urandom_range(15) == 0);
        err_ack = err_req;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] a, input logic [5:0] l, input int pct);
        int g;
        int i;
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        for (g = 0; g < 100; g++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        if (g == 100) begin
            checks++; failures++;
            $display("FAIL cmd_accept: timeout waiting for cmd_ready");
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        if (a == 2'd3 || l == 6'd0) return;
        i = 0;
        g = 0;
        while (i < int'(l) && g < 2000) begin
            @(posedge clock); #1;
            pl_valid = ($urandom_range(99) < pct);
            pl_data = pl_valid ? pb[i] : 8'($urandom);
            @(negedge clock);
            if (pl_valid && pl_ready) i++;
            g++;
        end
        if (i < int'(l)) begin
            checks++; failures++;
            $display("FAIL payload_load: only %0d of %0d bytes taken", i, l);
        end
        @(posedge clock); #1;
        pl_valid = 1'b0;
    endtask

    task automatic wait_done(output logic e);
        bit seen;
        seen = 1'b0;
        e = 1'b0;
        for (int g = 0; g < 3000 && !seen; g++) begin
            @(negedge clock);
            if (tx_done) begin
                e = tx_err;
                seen = 1'b1;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_done: no tx_done got 0 expected 1");
        end
    endtask

    initial begin
        logic e;
        int   pv0, c0, mism;
        logic [7:0] p;
        logic [1:0] a;
        logic [5:0] l;

        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
`ifdef ROUTER_TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        pl_valid = 1'b0;
        pl_data = '0;
        busy = 1'b0;
        err_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // basic packet, no busy
        pb[0] = 8'hA5; pb[1] = 8'h3C; pb[2] = 8'h0F;
        pv0 = pv_cnt;
        issue(2'd1, 6'd3, 100);
        wait_done(e);
        check("t1_tx_err", 32'(e), 0);
        check("t1_rx_n", 32'(rx_n), 4);
        check("t1_header", 32'(rx[0]), 32'h0D);
        check("t1_b1", 32'(rx[1]), 32'hA5);
        check("t1_b3", 32'(rx[3]), 32'h0F);
        check("t1_parity", 32'(rx_par), 32'h9B); // 0D^A5^3C^0F
        check("t1_pv_cycles", 32'(pv_cnt - pv0), 4);

        // busy for 2 cycles while 3C is presented
        busy_mode = 2;
        c0 = c3c;
        issue(2'd1, 6'd3, 100);
        wait_done(e);
        busy_mode = 0;
        check("t2_hold_3c", 32'(c3c - c0), 3);
        check("t2_rx_n", 32'(rx_n), 4);
        check("t2_b2", 32'(rx[2]), 32'h3C);
        check("t2_b3", 32'(rx[3]), 32'h0F);
        check("t2_parity", 32'(rx_par), 32'h9B);

        // illegal commands
        pv0 = pv_cnt;
        issue(2'd3, 6'd4, 100);
        wait_done(e);
        check("t3_addr3_err", 32'(e), 1);
        issue(2'd0, 6'd0, 100);
        wait_done(e);
        check("t3_len0_err", 32'(e), 1);
        check("t3_no_bus", 32'(pv_cnt - pv0), 0);

        // max length, payload valid half the time
        for (int i = 0; i < 63; i++) pb[i] = 8'($urandom);
        p = {6'd63, 2'd2};
        for (int i = 0; i < 63; i++) p ^= pb[i];
        pv0 = pv_cnt;
        issue(2'd2, 6'd63, 50);
        wait_done(e);
        check("t4_tx_err", 32'(e), 0);
        check("t4_pv_cycles", 32'(pv_cnt - pv0), 64);
        check("t4_parity", 32'(rx_par), 32'(p));

`ifdef ROUTER_TX_ERR_INJECT_EN
        for (int i = 0; i < 5; i++) pb[i] = 8'($urandom);
        p = {6'd5, 2'd0};
        for (int i = 0; i < 5; i++) p ^= pb[i];
        inject_err = 1'b1;
        issue(2'd0, 6'd5, 100);
        inject_err = 1'b0;
        wait_done(e);
        check("t5_inj_err", 32'(e), 1);
        check("t5_inj_parity", 32'(rx_par), 32'(~p));
`endif

        // random traffic with busy and stray err_in
        busy_mode = 1;
        spurious = 1'b1;
        for (int t = 0; t < 16; t++) begin
            a = 2'($urandom_range(3));
            l = ($urandom_range(9) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
            for (int i = 0; i < 64; i++) pb[i] = 8'($urandom);
            issue(a, l, int'($urandom_range(100, 30)));
            wait_done(e);
            if (a != 2'd3 && l != 6'd0) begin
                mism = (rx_n != int'(l) + 1) ? 1 : 0;
                for (int i = 0; i < int'(l); i++)
                    if (rx[i + 1] !== pb[i]) mism++;
                check("rand_payload", 32'(mism), 0);
            end
        end
        busy_mode = 0;
        spurious = 1'b0;
        repeat (2) @(posedge clock);

        // reset in the middle of the payload
        for (int i = 0; i < 5; i++) pb[i] = 8'(i * 17 + 3);
        issue(2'd1, 6'd5, 100);
        begin
            bit hit;
            hit = 1'b0;
            for (int g = 0; g < 200 && !hit; g++) begin
                @(negedge clock);
                if (pkt_valid && data_out == pb[1]) hit = 1'b1;
            end
            if (!hit) begin
                checks++; failures++;
                $display("FAIL t6_reach_payload: payload byte not seen");
            end
        end
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        check("t6_abort_pkt_valid", 32'(pkt_valid), 0);
        check("t6_abort_data", 32'(data_out), 0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("t6_ready_first", 32'(cmd_ready), 0);
        @(negedge clock);
        check("t6_ready_after", 32'(cmd_ready), 1);
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
